// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Accepts one unsigned value, spends BIN_W cycles in SHIFT, then presents the
// BCD digits (digit 0 least significant) until the consumer takes them.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds in_valid/in_bin until in_ready; the block
// holds out_valid/out_bcd/out_ovf until out_ready. Neither ready depends
// combinationally on the matching valid.
module bin2bcd_seq_ctrl #(
  parameter int BIN_W = 8,
  parameter int DIG   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIN_W-1:0]   in_bin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*DIG-1:0]   out_bcd,
  output logic               out_ovf,
  output logic               busy
);

  localparam int ACC_W = 4 * DIG;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   sreg_q, sreg_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   out_bcd_q, out_bcd_d;
  logic               out_ovf_q, out_ovf_d;

  // One double-dabble step on the current accumulator.
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_shift;
  logic               carry_out;

  // Digit correction then left shift of {acc, sreg}; carry_out is the bit
  // that falls off the top digit and marks a value too wide for DIG digits.
  always_comb begin
    acc_adj = acc_q;
    for (int k = 0; k < DIG; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
    carry_out = acc_adj[ACC_W-1];
    acc_shift = {acc_adj[ACC_W-2:0], sreg_q[BIN_W-1]};
  end

  // Next-state and datapath updates; every register holds by default.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    out_bcd_d = out_bcd_q;
    out_ovf_d = out_ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d  = in_bin;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = {sreg_q[BIN_W-2:0], 1'b0};
        acc_d  = acc_shift;
        ovf_d  = ovf_q | carry_out;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          out_bcd_d = acc_shift;
          out_ovf_d = ovf_q | carry_out;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      out_bcd_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      out_bcd_q <= out_bcd_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign out_valid = (state_q == DONE);
  assign out_bcd   = out_bcd_q;
  assign out_ovf   = out_ovf_q;

endmodule
